myaccip_axil_regs: RTL and testbench

MYACCIP_AXIL_REGS -- requirements
Module: myaccip_axil_regs

---
 rtl/myaccip_axil_regs.sv | 233 +++++++++++++++++++++++
 tb/tb_myaccip_axil_regs.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myaccip_axil_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// myaccip_axil_regs: AXI4-Lite slave with four 32-bit R/W registers, byte strobes
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module myaccip_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3,
  output logic [3:0]                      WR_PULSE
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int NUM_REGS = 4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_HELD = 2'd1,
    W_DATA_HELD = 2'd2,
    W_RESP      = 2'd3
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t             wstate_q, wstate_d;
  rstate_t             rstate_q, rstate_d;
  logic                rdy_en_q;
  logic [2:0]          awidx_q, awidx_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [3:0]          wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs, w_hs, ar_hs;
  logic [2:0]          aw_idx, ar_idx;
  logic                commit;
  logic [2:0]          cm_idx;
  logic [DW-1:0]       cm_data;
  logic [STRB_W-1:0]   cm_strb;
  logic                unused_inputs;

  // Byte offset and protection bits carry no meaning for this register file.
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_idx = S_AXI_AWADDR[4:2];
  assign ar_idx = S_AXI_ARADDR[4:2];

  // Readies stay low until one edge after reset release.
  assign S_AXI_AWREADY = rdy_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_DATA_HELD));
  assign S_AXI_WREADY  = rdy_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_ADDR_HELD));
  assign S_AXI_ARREADY = rdy_en_q && (rstate_q == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign S_AXI_BVALID = (wstate_q == W_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (rstate_q == R_DATA);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

  assign REG0     = regs_q[0];
  assign REG1     = regs_q[1];
  assign REG2     = regs_q[2];
  assign REG3     = regs_q[3];
  assign WR_PULSE = wr_pulse_q;

  always_comb begin
    wstate_d   = wstate_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    commit     = 1'b0;
    cm_idx     = awidx_q;
    cm_data    = wdata_q;
    cm_strb    = wstrb_q;

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          cm_idx  = aw_idx;
          cm_data = S_AXI_WDATA;
          cm_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          awidx_d  = aw_idx;
          wstate_d = W_ADDR_HELD;
        end else if (w_hs) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wstate_d = W_DATA_HELD;
        end
      end
      W_ADDR_HELD: begin
        if (w_hs) begin
          commit  = 1'b1;
          cm_idx  = awidx_q;
          cm_data = S_AXI_WDATA;
          cm_strb = S_AXI_WSTRB;
        end
      end
      W_DATA_HELD: begin
        if (aw_hs) begin
          commit  = 1'b1;
          cm_idx  = aw_idx;
          cm_data = wdata_q;
          cm_strb = wstrb_q;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    // Index bit 2 set means the word lies beyond the four mapped registers.
    if (commit) begin
      wstate_d = W_RESP;
      if (!cm_idx[2]) begin
        bresp_d                 = RESP_OKAY;
        wr_pulse_d[cm_idx[1:0]] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (cm_strb[b]) begin
            regs_d[cm_idx[1:0]][8*b +: 8] = cm_data[8*b +: 8];
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          if (!ar_idx[2]) begin
            rdata_d = regs_q[ar_idx[1:0]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      rdy_en_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      rdy_en_q   <= 1'b1;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_myaccip_axil_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_myaccip_axil_regs: scoreboard bench for the AXI4-Lite register block
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_myaccip_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] REG0, REG1, REG2, REG3;
  logic [3:0]  WR_PULSE;

  myaccip_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3),
    .WR_PULSE(WR_PULSE)
  );

  always #5 ACLK = ~ACLK;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  bq [$];
  logic [1:0]  rq_resp [$];
  logic [31:0] rq_data [$];
  int          pulse_cnt [4];
  int          snap [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: compares each response the DUT hands over.
  logic [1:0]  eb, er;
  logic [31:0] ed;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_AXI_BVALID && bq.size() == 0) begin
        chk("b_unsolicited", {31'd0, S_AXI_BVALID}, 32'd0);
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        eb = bq.pop_front();
        chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, eb});
      end
      if (S_AXI_RVALID && rq_resp.size() == 0) begin
        chk("r_unsolicited", {31'd0, S_AXI_RVALID}, 32'd0);
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        er = rq_resp.pop_front();
        ed = rq_data.pop_front();
        chk("rresp", {30'd0, S_AXI_RRESP}, {30'd0, er});
        chk("rdata", S_AXI_RDATA, ed);
      end
    end
  end

  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) begin
      if (WR_PULSE[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #1;
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4; i++) snap[i] = pulse_cnt[i];
  endtask

  task automatic chk_pulses(input string nm, input logic [3:0] exp_mask);
    for (int i = 0; i < 4; i++) begin
      chk(nm, pulse_cnt[i] - snap[i], {31'd0, exp_mask[i]});
    end
  endtask

  task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    bq.push_back(exp_resp);
    S_AXI_AWADDR = a;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    while (!(aw_done && w_done) && cyc < 30) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) chk("write_hs_timeout", 32'd0, 32'd1);
    else chk("bvalid_latency", {31'd0, S_AXI_BVALID}, 32'd1);
  endtask

  task automatic wait_b();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) seen = 1;
      @(posedge ACLK); #1;
      n++;
    end
    if (!seen) chk("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_read(input logic [4:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    int n = 0;
    bit done = 0;
    rq_resp.push_back(exp_resp);
    rq_data.push_back(exp_data);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    while (!done && n < 20) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) done = 1;
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) chk("ar_hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_r();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) seen = 1;
      @(posedge ACLK); #1;
      n++;
    end
    if (!seen) chk("r_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    issue_write(a, d, s, aw_dly, w_dly, exp_resp);
    wait_b();
  endtask

  task automatic do_read(input logic [4:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    issue_read(a, exp_resp, exp_data);
    wait_r();
  endtask

  task automatic chk_regs(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    chk({nm, "_reg0"}, REG0, e0);
    chk({nm, "_reg1"}, REG1, e1);
    chk({nm, "_reg2"}, REG2, e2);
    chk({nm, "_reg3"}, REG3, e3);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk_regs(nm, 32'h0, 32'h0, 32'h0, 32'h0);
    chk({nm, "_wr_pulse"}, {28'd0, WR_PULSE}, 32'd0);
    chk({nm, "_bvalid"}, {31'd0, S_AXI_BVALID}, 32'd0);
    chk({nm, "_rvalid"}, {31'd0, S_AXI_RVALID}, 32'd0);
    chk({nm, "_bresp"}, {30'd0, S_AXI_BRESP}, 32'd0);
    chk({nm, "_rresp"}, {30'd0, S_AXI_RRESP}, 32'd0);
    chk({nm, "_rdata"}, S_AXI_RDATA, 32'd0);
    chk({nm, "_awready"}, {31'd0, S_AXI_AWREADY}, 32'd0);
    chk({nm, "_wready"}, {31'd0, S_AXI_WREADY}, 32'd0);
    chk({nm, "_arready"}, {31'd0, S_AXI_ARREADY}, 32'd0);
  endtask

  initial begin
    ARESET        = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = 3'b010;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = 3'b101;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;

    // Reset state and ready release timing
    idle(3);
    chk_reset_outputs("rst");
    ARESET = 1'b0;
    #1;
    chk("rst_release_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    @(posedge ACLK); #1;
    chk("post_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    chk("post_rst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    chk("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

    // Simultaneous AW+W writes then readback
    do_write(5'h00, 32'h1, 4'hF, 0, 0, OKAY);
    do_write(5'h04, 32'h2, 4'hF, 0, 0, OKAY);
    do_write(5'h08, 32'h3, 4'hF, 0, 0, OKAY);
    do_write(5'h0C, 32'h4, 4'hF, 0, 0, OKAY);
    chk_regs("basic", 32'h1, 32'h2, 32'h3, 32'h4);
    do_read(5'h00, OKAY, 32'h1);
    do_read(5'h04, OKAY, 32'h2);
    do_read(5'h08, OKAY, 32'h3);
    do_read(5'h0C, OKAY, 32'h4);

    // Address-first and data-first orderings
    do_write(5'h04, 32'hDEADBEEF, 4'hF, 0, 3, OKAY);
    do_write(5'h08, 32'hCAFEF00D, 4'hF, 3, 0, OKAY);
    chk_regs("split", 32'h1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h4);
    do_read(5'h04, OKAY, 32'hDEADBEEF);
    do_read(5'h08, OKAY, 32'hCAFEF00D);

    // Byte strobes and commit pulse
    do_write(5'h00, 32'h11223344, 4'hF, 0, 0, OKAY);
    idle(1);
    take_snap();
    do_write(5'h00, 32'hAABBCCDD, 4'h5, 0, 0, OKAY);
    idle(2);
    chk("strb_reg0", REG0, 32'h11BB33DD);
    chk_pulses("strb_pulse", 4'b0001);

    take_snap();
    do_write(5'h0A, 32'hFFFFFFFF, 4'h0, 1, 0, OKAY);
    idle(2);
    chk("strb0_reg2", REG2, 32'hCAFEF00D);
    chk_pulses("strb0_pulse", 4'b0100);

    // Unmapped accesses
    take_snap();
    do_write(5'h14, 32'h12345678, 4'hF, 0, 0, SLVERR);
    do_read(5'h1C, SLVERR, 32'h0);
    idle(2);
    chk_regs("unmapped", 32'h11BB33DD, 32'hDEADBEEF, 32'hCAFEF00D, 32'h4);
    chk_pulses("unmapped_pulse", 4'b0000);

    // Read on the same edge as a write commit returns the old value
    fork
      do_write(5'h00, 32'h00000055, 4'hF, 0, 0, OKAY);
      do_read(5'h00, OKAY, 32'h11BB33DD);
    join
    do_read(5'h03, OKAY, 32'h00000055);

    // Back-pressure: responses held while BREADY/RREADY are low
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    issue_write(5'h08, 32'h00000077, 4'hF, 0, 0, OKAY);
    issue_read(5'h04, OKAY, 32'hDEADBEEF);
    S_AXI_AWADDR  = 5'h00;
    S_AXI_WDATA   = 32'hBAD0BAD0;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_ARADDR  = 5'h0C;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("hold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      chk("hold_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
      chk("hold_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
      chk("hold_rdata", S_AXI_RDATA, 32'hDEADBEEF);
      chk("hold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      chk("hold_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      chk("hold_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_RREADY  = 1'b1;
    fork
      wait_b();
      wait_r();
    join
    idle(1);
    chk_regs("hold", 32'h00000055, 32'hDEADBEEF, 32'h00000077, 32'h4);

    // Reset while the write FSM holds an address
    do_write(5'h0C, 32'h00000005, 4'hF, 0, 0, OKAY);
    chk("pre_rst_reg3", REG3, 32'h5);
    S_AXI_AWADDR  = 5'h0C;
    S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    chk("addr_held_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    chk("addr_held_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    ARESET = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    idle(2);
    ARESET = 1'b0;
    idle(1);
    do_write(5'h0C, 32'h00000009, 4'hF, 0, 0, OKAY);
    do_read(5'h0C, OKAY, 32'h00000009);
    do_read(5'h00, OKAY, 32'h0);
    idle(2);
    chk("queues_drained", bq.size() + rq_resp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
